// File: rtl/rf_mp_param_if.sv
// Bus bundle for rf_mp_param: two write ports, two read ports, clear/busy.
// master drives addresses, data, enables and CLR; slave returns Qa/Qb/BUSY.
interface rf_mp_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] Ra;
    logic [ADDR_W-1:0] Rb;
    logic              RD_en;
    logic [ADDR_W-1:0] WA0;
    logic [DATA_W-1:0] WD0;
    logic              WE0;
    logic [ADDR_W-1:0] WA1;
    logic [DATA_W-1:0] WD1;
    logic              WE1;
    logic              CLR;
    logic [DATA_W-1:0] Qa;
    logic [DATA_W-1:0] Qb;
    logic              BUSY;

    modport master (
        output Ra, Rb, RD_en,
        output WA0, WD0, WE0,
        output WA1, WD1, WE1,
        output CLR,
        input  Qa, Qb, BUSY
    );

    modport slave (
        input  Ra, Rb, RD_en,
        input  WA0, WD0, WE0,
        input  WA1, WD1, WE1,
        input  CLR,
        output Qa, Qb, BUSY
    );
endinterface

// File: rtl/rf_mp_param.sv
// Dual-write, dual-read register file with write bypass and a bulk-clear sweep.
// Ports: CLK, RST (async, active-high), bus (rf_mp_param_if.slave).
module rf_mp_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input logic         CLK,
    input logic         RST,
    rf_mp_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] qa_q, qa_d;
    logic [DATA_W-1:0] qb_q, qb_d;
    logic              wr_ok;
    logic              we0;
    logic              we1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        qa_d    = qa_q;
        qb_d    = qb_q;
        // An edge that samples CLR starts the sweep and drops its writes.
        wr_ok = (state_q == IDLE) && !bus.CLR;
        we0 = wr_ok && bus.WE0
            && !((ZERO_REG != 0) && (bus.WA0 == '0));
        we1 = wr_ok && bus.WE1
            && !((ZERO_REG != 0) && (bus.WA1 == '0));
        unique case (state_q)
            IDLE: begin
                if (bus.CLR) state_d = SWEEP;
                if (we0) mem_d[bus.WA0] = bus.WD0;
                // Port 1 applied last so it wins a collision.
                if (we1) mem_d[bus.WA1] = bus.WD1;
                // Reading the post-write array gives the bypass for free;
                // entry 0 is never written when hardwired, so stays 0.
                if (bus.RD_en && !bus.CLR) begin
                    qa_d = mem_d[bus.Ra];
                    qb_d = mem_d[bus.Rb];
                end
            end
            SWEEP: begin
                mem_d[cnt_q] = '0;
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mem_q   <= '{default: '0};
            qa_q    <= '0;
            qb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            qa_q    <= qa_d;
            qb_q    <= qb_d;
        end
    end

    assign bus.Qa   = qa_q;
    assign bus.Qb   = qb_q;
    assign bus.BUSY = (state_q == SWEEP);
endmodule

// File: tb/tb_rf_mp_param.sv
// Bench for rf_mp_param: vector table plus scoreboarded read sequences.
// A ZERO_REG=0 twin shares all stimulus to check the non-hardwired entry 0.
module tb_rf_mp_param;
    localparam int DW = 32;
    localparam int AW = 5;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   total = 0;
    int   bad   = 0;

    rf_mp_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    rf_mp_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus_z ();

    assign bus_z.Ra    = bus.Ra;
    assign bus_z.Rb    = bus.Rb;
    assign bus_z.RD_en = bus.RD_en;
    assign bus_z.WA0   = bus.WA0;
    assign bus_z.WD0   = bus.WD0;
    assign bus_z.WE0   = bus.WE0;
    assign bus_z.WA1   = bus.WA1;
    assign bus_z.WD1   = bus.WD1;
    assign bus_z.WE1   = bus.WE1;
    assign bus_z.CLR   = bus.CLR;

    rf_mp_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    rf_mp_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut_z (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_z.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [DW-1:0] qa;
        logic [DW-1:0] qb;
    } exp_t;

    typedef struct packed {
        logic          we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          rd;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [DW-1:0] qa;
        logic [DW-1:0] qb;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[12];

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_in();
        bus.WE0   = 1'b0;
        bus.WE1   = 1'b0;
        bus.CLR   = 1'b0;
        bus.RD_en = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        e.qa = a;
        e.qb = b;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            chk({name, "_qa"}, bus.Qa, e.qa);
            chk({name, "_qb"}, bus.Qb, e.qb);
        end
    endtask

    task automatic rd_check(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                            input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                            input string name);
        bus.RD_en = 1'b1;
        bus.Ra    = ra;
        bus.Rb    = rb;
        push(ea, eb);
        step();
        pop_chk(name);
        clr_in();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.Ra = '0; bus.Rb = '0; bus.RD_en = 1'b0;
        bus.WA0 = '0; bus.WD0 = '0; bus.WE0 = 1'b0;
        bus.WA1 = '0; bus.WD1 = '0; bus.WE1 = 1'b0;
        bus.CLR = 1'b0;

        // Reset state
        #12;
        chk("rst_qa", bus.Qa, '0);
        chk("rst_qb", bus.Qb, '0);
        chk("rst_busy", DW'(bus.BUSY), '0);
        step();
        RST = 1'b0;

        // Basic write / read
        bus.WE0 = 1'b1; bus.WA0 = 5'd5; bus.WD0 = 32'hA5A5A5A5;
        step();
        clr_in();
        bus.WE1 = 1'b1; bus.WA1 = 5'd10; bus.WD1 = 32'h5A5A5A5A;
        step();
        clr_in();
        rd_check(5'd5, 5'd10, 32'hA5A5A5A5, 32'h5A5A5A5A, "basic");
        rd_check(5'd15, 5'd20, '0, '0, "unwritten");

        // Collision, zero register, bypass, read hold
        tbl[0]  = '{1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222,
                    1'b0, 5'd0, 5'd0, 32'h0, 32'h0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 5'd7, 5'd5, 32'h22222222, 32'hA5A5A5A5};
        tbl[2]  = '{1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,
                    1'b0, 5'd0, 5'd0, 32'h22222222, 32'hA5A5A5A5};
        tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 5'd0, 5'd0, 32'h0, 32'h0};
        tbl[4]  = '{1'b1, 5'd3, 32'hCAFEF00D, 1'b0, 5'd0, 32'h0,
                    1'b1, 5'd3, 5'd5, 32'hCAFEF00D, 32'hA5A5A5A5};
        tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h0BADF00D,
                    1'b1, 5'd7, 5'd3, 32'h22222222, 32'h0BADF00D};
        tbl[6]  = '{1'b1, 5'd9, 32'h11112222, 1'b1, 5'd9, 32'h33334444,
                    1'b1, 5'd9, 5'd9, 32'h33334444, 32'h33334444};
        tbl[7]  = '{1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'h0,
                    1'b0, 5'd5, 5'd10, 32'h33334444, 32'h33334444};
        tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h87654321,
                    1'b0, 5'd3, 5'd7, 32'h33334444, 32'h33334444};
        tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 5'd5, 5'd10, 32'h12345678, 32'h87654321};
        tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF,
                    1'b1, 5'd0, 5'd3, 32'h0, 32'h0BADF00D};
        tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 5'd7, 5'd7, 32'h22222222, 32'h22222222};
        for (int i = 0; i < 12; i++) begin
            bus.WE0 = tbl[i].we0; bus.WA0 = tbl[i].wa0; bus.WD0 = tbl[i].wd0;
            bus.WE1 = tbl[i].we1; bus.WA1 = tbl[i].wa1; bus.WD1 = tbl[i].wd1;
            bus.RD_en = tbl[i].rd; bus.Ra = tbl[i].ra; bus.Rb = tbl[i].rb;
            push(tbl[i].qa, tbl[i].qb);
            step();
            pop_chk($sformatf("vec%0d", i));
        end
        clr_in();

        // Non-hardwired twin keeps the last write to entry 0 (FFFFFFFF)
        rd_check(5'd0, 5'd0, '0, '0, "zreg_on");
        chk("zreg_off", bus_z.Qa, 32'hFFFFFFFF);

        // Bulk clear
        for (int i = 1; i < 32; i++) begin
            bus.WE0 = 1'b1; bus.WA0 = AW'(i); bus.WD0 = DW'(i);
            step();
        end
        clr_in();
        rd_check(5'd4, 5'd7, 32'd4, 32'd7, "prefill");
        bus.CLR = 1'b1;
        bus.WE0 = 1'b1; bus.WA0 = 5'd4; bus.WD0 = 32'hFFFFFFFF;
        bus.RD_en = 1'b1; bus.Ra = 5'd1; bus.Rb = 5'd2;
        push(32'd4, 32'd7);
        step();
        pop_chk("clr_edge");
        clr_in();
        chk("busy_rise", DW'(bus.BUSY), 32'd1);
        n = 0;
        while (bus.BUSY === 1'b1 && n < 100) begin
            n++;
            bus.WE0 = 1'b1; bus.WA0 = 5'd8; bus.WD0 = DW'(n);
            bus.RD_en = 1'b1; bus.Ra = 5'd8; bus.Rb = 5'd4;
            bus.CLR = (n == 5);
            push(32'd4, 32'd7);
            step();
            pop_chk("sweep_hold");
        end
        clr_in();
        chk("busy_len", DW'(n), 32'd32);
        for (int i = 0; i < 32; i++)
            rd_check(AW'(i), AW'(31 - i), '0, '0, "swept");

        // Reset mid-sweep
        bus.WE0 = 1'b1; bus.WA0 = 5'd6; bus.WD0 = 32'h00000066;
        step();
        clr_in();
        rd_check(5'd6, 5'd6, 32'h66, 32'h66, "pre_rst");
        bus.CLR = 1'b1;
        step();
        clr_in();
        repeat (10) step();
        chk("mid_busy", DW'(bus.BUSY), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_busy", DW'(bus.BUSY), '0);
        chk("arst_qa", bus.Qa, '0);
        chk("arst_qb", bus.Qb, '0);
        step();
        RST = 1'b0;
        bus.WE0 = 1'b1; bus.WA0 = 5'd12; bus.WD0 = 32'h00C0FFEE;
        rd_check(5'd12, 5'd6, 32'h00C0FFEE, '0, "post_rst");
        for (int i = 0; i < 32; i++)
            rd_check(AW'(i), AW'(i),
                     (i == 12) ? 32'h00C0FFEE : 32'h0,
                     (i == 12) ? 32'h00C0FFEE : 32'h0, "post_rst_scan");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rf_mp_param.md
Name: rf_mp_param

Overview:
- Parametrised multi-port register file for the dual-core processor.
- Two synchronous write ports, one per core. Two registered read ports.
- Write-to-read bypass, optional hardwired-zero register 0, asynchronous reset.
- Sequenced bulk-clear engine that zeroes the array one entry per cycle while asserting BUSY.

Parameters:
- DATA_W, 32, width of each register.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, when 1, entry 0 reads as 0 and ignores writes.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- Ra  in  ADDR_W  read address, port A.
- Rb  in  ADDR_W  read address, port B.
- RD_en  in  1  read enable for both read ports.
- WA0  in  ADDR_W  write address, port 0 (core 0).
- WD0  in  DATA_W  write data, port 0.
- WE0  in  1  write enable, port 0.
- WA1  in  ADDR_W  write address, port 1 (core 1).
- WD1  in  DATA_W  write data, port 1.
- WE1  in  1  write enable, port 1.
- CLR  in  1  bulk-clear request, sampled on rising edge.
- Qa  out  DATA_W  registered read data, port A.
- Qb  out  DATA_W  registered read data, port B.
- BUSY  out  1  high while the clear sweep runs.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. RST=1 immediately forces:
  - all DEPTH entries to 0;
  - Qa=0, Qb=0, BUSY=0;
  - FSM to IDLE, sweep counter to 0.
- Reset takes effect at any time, including mid-sweep; operation resumes on the first edge after RST falls.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP on an edge with CLR=1.
  - SWEEP -> IDLE on the edge that clears entry DEPTH-1.
- BUSY = (state==SWEEP). It rises one cycle after CLR is sampled and stays high for exactly DEPTH cycles.
- Sweep:
  - On each edge in SWEEP, entry[cnt] is set to 0 and cnt increments.
  - cnt wraps from DEPTH-1 to 0 on exit.
  - CLR in SWEEP is ignored; no restart.
- Writes (IDLE only), on each edge:
  - entry[WA0] <= WD0 if WE0;
  - entry[WA1] <= WD1 if WE1.
- Write collision: WE0 and WE1 on the same address -> port 1 data is stored.
- Zero register: if ZERO_REG=1, writes to address 0 are discarded.
- CLR edge: writes presented on the same edge that samples CLR in IDLE are discarded.
- Writes during SWEEP are discarded with no error indication.
- Reads (IDLE, RD_en=1, CLR=0):
  - on the edge, Qa <= value of entry Ra and Qb <= value of entry Rb; latency 1 cycle.
- Bypass: if a write to Ra (or Rb) is committed on the same edge, Qa (Qb) gets the new write data. Port 1 data wins when both ports hit the address.
- ZERO_REG=1 with Ra=0 (Rb=0) returns 0 regardless of writes.
- Hold conditions: Qa/Qb hold their previous value when:
  - RD_en=0;
  - during SWEEP;
  - on the edge that samples CLR.
- Ra=Rb is legal; both outputs carry the same data.
- All address values 0..DEPTH-1 are valid; no out-of-range case exists.

Test Plan:
1. Reset then basic write/read: RST pulse; WE0=1, WA0=5, WD0=A5A5A5A5; next cycle WE1=1, WA1=10, WD1=5A5A5A5A; then RD_en=1, Ra=5, Rb=10 -> one edge later Qa=A5A5A5A5, Qb=5A5A5A5A. Unwritten Ra=15, Rb=20 -> Qa=0, Qb=0.
2. Collision and zero register: same edge WE0/WE1 to address 7 with 11111111/22222222 -> read 7 gives 22222222. Write DEADBEEF to address 0 with ZERO_REG=1 -> read 0 gives 0. Repeat with ZERO_REG=0 -> DEADBEEF.
3. Bypass: RD_en=1, Ra=3, WE0=1, WA0=3, WD0=CAFEF00D on the same edge -> Qa=CAFEF00D after that edge. Rb=3 with WE1 to 3 = 0BADF00D on the same edge -> Qb=0BADF00D.
4. Bulk clear: fill entries 1..31 with their index; pulse CLR with WE0 to 4 = FFFFFFFF on the same edge.
   - BUSY is high for exactly 32 cycles.
   - Writes and reads during BUSY are ignored; Qa/Qb hold their values.
   - After BUSY falls, every entry reads 0, including entry 4.
   - A second CLR pulse mid-sweep does not extend BUSY.
5. Reset mid-sweep: assert RST asynchronously (between edges) at sweep cycle 10 -> BUSY=0, Qa=Qb=0 immediately. After release, writes and reads work on the next edge and all entries read 0.
6. Read hold: RD_en=0 while Ra/Rb change and writes occur -> Qa/Qb are unchanged until RD_en returns to 1.
